// File: rtl/axi_lite_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI-lite read-channel arbiter.
// One outstanding read at a time; grant registered in IDLE, round-robin or LSU-first.
module axi_lite_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  input  logic                  ifu_rready_i,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  input  logic                  lsu_rready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   grant;       // 0 = IFU, 1 = LSU
  logic   last_grant;
  logic   next_grant;
  logic   gnt_arvalid;
  logic   gnt_rready;
  logic   in_addr;
  logic   in_data;

  always_comb begin
    next_grant = lsu_arvalid_i;
    if (ifu_arvalid_i && lsu_arvalid_i)
      next_grant = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
  end

  assign gnt_arvalid = grant ? lsu_arvalid_i : ifu_arvalid_i;
  assign gnt_rready  = grant ? lsu_rready_i  : ifu_rready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_arvalid_i || lsu_arvalid_i) begin
            grant <= next_grant;
            state <= ADDR;
          end
        end
        ADDR: begin
          // A withdrawn request abandons the slot without touching last_grant
          if (!gnt_arvalid)   state <= IDLE;
          else if (arready_i) state <= DATA;
        end
        DATA: begin
          if (rvalid_i && gnt_rready) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign arvalid_o     = in_addr & gnt_arvalid;
  assign araddr_o      = in_addr ? (grant ? lsu_araddr_i : ifu_araddr_i) : '0;
  assign ifu_arready_o = in_addr & ~grant & arready_i;
  assign lsu_arready_o = in_addr &  grant & arready_i;

  assign rready_o      = in_data & gnt_rready;
  assign ifu_rvalid_o  = in_data & ~grant & rvalid_i;
  assign lsu_rvalid_o  = in_data &  grant & rvalid_i;
  assign ifu_rdata_o   = rdata_i;
  assign lsu_rdata_o   = rdata_i;

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: a round-robin and a fixed-priority instance,
// each behind a minimal single-outstanding slave model.
module tb_axi_lite_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr;
  logic        ifu_arvalid, lsu_arvalid, ifu_rready, lsu_rready;
  logic        slv_ar_rdy;
  logic [63:0] slv_data;

  logic        rr_ifu_arready, rr_ifu_rvalid, rr_lsu_arready, rr_lsu_rvalid;
  logic [63:0] rr_ifu_rdata, rr_lsu_rdata, rr_rdata;
  logic [31:0] rr_araddr;
  logic        rr_arvalid, rr_rvalid, rr_rready, rr_busy;

  logic        fp_ifu_arready, fp_ifu_rvalid, fp_lsu_arready, fp_lsu_rvalid;
  logic [63:0] fp_ifu_rdata, fp_lsu_rdata, fp_rdata;
  logic [31:0] fp_araddr;
  logic        fp_arvalid, fp_rvalid, fp_rready, fp_busy;
  logic        fp_arready;

  int vectors = 0;
  int miscompares = 0;

  assign fp_arready = 1'b1;

  always #5 clk = ~clk;

  axi_lite_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .FIXED_PRIO(0)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(rr_ifu_arready),
    .ifu_rdata_o(rr_ifu_rdata), .ifu_rvalid_o(rr_ifu_rvalid), .ifu_rready_i(ifu_rready),
    .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(rr_lsu_arready),
    .lsu_rdata_o(rr_lsu_rdata), .lsu_rvalid_o(rr_lsu_rvalid), .lsu_rready_i(lsu_rready),
    .araddr_o(rr_araddr), .arvalid_o(rr_arvalid), .arready_i(slv_ar_rdy),
    .rdata_i(rr_rdata), .rvalid_i(rr_rvalid), .rready_o(rr_rready), .busy_o(rr_busy)
  );

  axi_lite_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(fp_ifu_arready),
    .ifu_rdata_o(fp_ifu_rdata), .ifu_rvalid_o(fp_ifu_rvalid), .ifu_rready_i(ifu_rready),
    .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(fp_lsu_arready),
    .lsu_rdata_o(fp_lsu_rdata), .lsu_rvalid_o(fp_lsu_rvalid), .lsu_rready_i(lsu_rready),
    .araddr_o(fp_araddr), .arvalid_o(fp_arvalid), .arready_i(fp_arready),
    .rdata_i(fp_rdata), .rvalid_i(fp_rvalid), .rready_o(fp_rready), .busy_o(fp_busy)
  );

  // Slave models: rvalid follows an AR handshake by one cycle, held until rready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_rvalid <= 1'b0;
      rr_rdata  <= '0;
    end else if (rr_arvalid && slv_ar_rdy) begin
      rr_rvalid <= 1'b1;
      rr_rdata  <= slv_data;
    end else if (rr_rvalid && rr_rready) begin
      rr_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_rvalid <= 1'b0;
      fp_rdata  <= '0;
    end else if (fp_arvalid && fp_arready) begin
      fp_rvalid <= 1'b1;
      fp_rdata  <= {32'h0, fp_araddr};
    end else if (fp_rvalid && fp_rready) begin
      fp_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    ifu_rready  = 1'b0; lsu_rready  = 1'b0;
    slv_ar_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; lsu_araddr = '0; slv_data = '0;
    clear_inputs();
    #12;
    chk("rst_busy",      64'(rr_busy), 64'd0);
    chk("rst_arvalid",   64'(rr_arvalid), 64'd0);
    chk("rst_araddr",    64'(rr_araddr), 64'd0);
    chk("rst_rready",    64'(rr_rready), 64'd0);
    chk("rst_arready",   64'({rr_ifu_arready, rr_lsu_arready}), 64'd0);
    chk("rst_rvalid",    64'({rr_ifu_rvalid, rr_lsu_rvalid}), 64'd0);
    chk("rst_fp_busy",   64'(fp_busy), 64'd0);
    rst = 1'b0;
    cyc();

    // IFU alone, zero-wait slave
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
    slv_ar_rdy = 1'b1; slv_data = 64'h0000_0013_0000_0297;
    #1;
    chk("t1_c0_arvalid", 64'(rr_arvalid), 64'd0);
    chk("t1_c0_busy",    64'(rr_busy), 64'd0);
    cyc();
    chk("t1_c1_arvalid", 64'(rr_arvalid), 64'd1);
    chk("t1_c1_araddr",  64'(rr_araddr), 64'h8000_0000);
    chk("t1_c1_ifu_ard", 64'(rr_ifu_arready), 64'd1);
    chk("t1_c1_lsu_ard", 64'(rr_lsu_arready), 64'd0);
    chk("t1_c1_lsu_rv",  64'(rr_lsu_rvalid), 64'd0);
    cyc();
    ifu_arvalid = 1'b0;
    #1;
    chk("t1_c2_ifu_rv",  64'(rr_ifu_rvalid), 64'd1);
    chk("t1_c2_rdata",   rr_ifu_rdata, 64'h0000_0013_0000_0297);
    chk("t1_c2_lsu_rv",  64'(rr_lsu_rvalid), 64'd0);
    chk("t1_c2_ifu_ard", 64'(rr_ifu_arready), 64'd0);
    cyc();
    chk("t1_c3_busy",    64'(rr_busy), 64'd0);
    chk("t1_c3_ifu_rv",  64'(rr_ifu_rvalid), 64'd0);

    // Round-robin on simultaneous requests: LSU, IFU, LSU
    do_reset();
    ifu_araddr = 32'h8000_0004; lsu_araddr = 32'h8000_1000;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    slv_ar_rdy = 1'b1; slv_data = 64'h1111_2222_3333_4444;
    cyc();
    chk("t2_a1_araddr",  64'(rr_araddr), 64'h8000_1000);
    chk("t2_a1_lsu_ard", 64'(rr_lsu_arready), 64'd1);
    chk("t2_a1_ifu_ard", 64'(rr_ifu_arready), 64'd0);
    cyc();
    lsu_arvalid = 1'b0;
    #1;
    chk("t2_d1_lsu_rv",  64'(rr_lsu_rvalid), 64'd1);
    chk("t2_d1_ifu_rv",  64'(rr_ifu_rvalid), 64'd0);
    chk("t2_d1_rdata",   rr_lsu_rdata, 64'h1111_2222_3333_4444);
    chk("t2_d1_ifu_ard", 64'(rr_ifu_arready), 64'd0);
    slv_data = 64'h5555_6666_7777_8888;
    cyc();
    chk("t2_i_busy",     64'(rr_busy), 64'd0);
    chk("t2_i_ifu_ard",  64'(rr_ifu_arready), 64'd0);
    cyc();
    chk("t2_a2_araddr",  64'(rr_araddr), 64'h8000_0004);
    chk("t2_a2_ifu_ard", 64'(rr_ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0;
    #1;
    chk("t2_d2_ifu_rv",  64'(rr_ifu_rvalid), 64'd1);
    chk("t2_d2_rdata",   rr_ifu_rdata, 64'h5555_6666_7777_8888);
    cyc();
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    cyc();
    chk("t2_a3_araddr",  64'(rr_araddr), 64'h8000_1000);
    chk("t2_a3_lsu_ard", 64'(rr_lsu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    #1;
    chk("t2_d3_lsu_rv",  64'(rr_lsu_rvalid), 64'd1);
    cyc();

    // Fixed priority: LSU wins every contested slot
    do_reset();
    ifu_araddr = 32'h8000_0004; lsu_araddr = 32'h8000_1000;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("t3_ifu_ard_%0d", k), 64'(fp_ifu_arready), 64'd0);
      chk($sformatf("t3_lsu_ard_%0d", k), 64'(fp_lsu_arready), (k % 3 == 1) ? 64'd1 : 64'd0);
      chk($sformatf("t3_lsu_rv_%0d", k),  64'(fp_lsu_rvalid),  (k % 3 == 2) ? 64'd1 : 64'd0);
      cyc();
    end
    clear_inputs();

    // Slave arready stall then master rready stall
    do_reset();
    lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1; slv_data = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("t4_arv_%0d", k),  64'(rr_arvalid), 64'd1);
      chk($sformatf("t4_addr_%0d", k), 64'(rr_araddr), 64'h8000_2000);
      chk($sformatf("t4_ard_%0d", k),  64'(rr_lsu_arready), 64'd0);
      chk($sformatf("t4_busy_%0d", k), 64'(rr_busy), 64'd1);
    end
    cyc();
    slv_ar_rdy = 1'b1;
    #1;
    chk("t4_ard_hs",     64'(rr_lsu_arready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      lsu_arvalid = 1'b0; slv_ar_rdy = 1'b0;
      #1;
      chk($sformatf("t4_rv_%0d", k),   64'(rr_lsu_rvalid), 64'd1);
      chk($sformatf("t4_rrdy_%0d", k), 64'(rr_rready), 64'd0);
      chk($sformatf("t4_bsy_%0d", k),  64'(rr_busy), 64'd1);
    end
    cyc();
    lsu_rready = 1'b1;
    #1;
    chk("t4_rv_final",   64'(rr_lsu_rvalid), 64'd1);
    chk("t4_rrdy_final", 64'(rr_rready), 64'd1);
    chk("t4_rdata",      rr_lsu_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    cyc();
    chk("t4_idle_busy",  64'(rr_busy), 64'd0);

    // IFU withdraws in ADDR; pending LSU served next
    do_reset();
    ifu_araddr = 32'h8000_0040; lsu_araddr = 32'h8000_3000;
    ifu_arvalid = 1'b1; lsu_rready = 1'b1; slv_data = 64'h0123_4567_89AB_CDEF;
    cyc();
    chk("t5_a_araddr",   64'(rr_araddr), 64'h8000_0040);
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b1;
    #1;
    chk("t5_a_arvalid",  64'(rr_arvalid), 64'd0);
    chk("t5_a_lsu_ard",  64'(rr_lsu_arready), 64'd0);
    cyc();
    chk("t5_i_busy",     64'(rr_busy), 64'd0);
    chk("t5_i_rvalid",   64'({rr_ifu_rvalid, rr_lsu_rvalid, rr_rvalid}), 64'd0);
    cyc();
    chk("t5_a2_araddr",  64'(rr_araddr), 64'h8000_3000);
    chk("t5_a2_arvalid", 64'(rr_arvalid), 64'd1);
    slv_ar_rdy = 1'b1;
    cyc();
    lsu_arvalid = 1'b0; slv_ar_rdy = 1'b0;
    #1;
    chk("t5_d_lsu_rv",   64'(rr_lsu_rvalid), 64'd1);
    chk("t5_d_rdata",    rr_lsu_rdata, 64'h0123_4567_89AB_CDEF);
    cyc();

    // Async reset while in DATA, then first tie goes to LSU again
    ifu_arvalid = 1'b1; ifu_rready = 1'b1; slv_ar_rdy = 1'b1;
    cyc();
    cyc();
    ifu_arvalid = 1'b0; slv_ar_rdy = 1'b0;
    #1;
    chk("t6_pre_rv",     64'(rr_ifu_rvalid), 64'd1);
    chk("t6_pre_rrdy",   64'(rr_rready), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_busy",       64'(rr_busy), 64'd0);
    chk("t6_arvalid",    64'(rr_arvalid), 64'd0);
    chk("t6_rready",     64'(rr_rready), 64'd0);
    chk("t6_rvalid",     64'({rr_ifu_rvalid, rr_lsu_rvalid}), 64'd0);
    rst = 1'b0;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; slv_ar_rdy = 1'b1;
    cyc();
    chk("t6_tie_araddr", 64'(rr_araddr), 64'h8000_3000);
    chk("t6_tie_ard",    64'(rr_lsu_arready), 64'd1);
    clear_inputs();
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Two-master, one-slave AXI-lite read-channel arbiter. Shares one read port between the IFU (master 0) and the LSU load path (master 1).
- Sits between the fetch/LSU read ports and the downstream AXI-lite read port (dram_axi_lite or the AXI master interface).
- Allows one outstanding read at a time. Grant is registered, with round-robin or fixed-priority selection.
- LSU write channels bypass this block.

Parameters:
ADDR_WIDTH, 32, address width of all AR channels
DATA_WIDTH, 64, read data width
FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = LSU always wins

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
ifu_araddr_i  input  ADDR_WIDTH  IFU read address
ifu_arvalid_i  input  1  IFU address valid
ifu_arready_o  output  1  IFU address accepted
ifu_rdata_o  output  DATA_WIDTH  IFU read data
ifu_rvalid_o  output  1  IFU read data valid
ifu_rready_i  input  1  IFU ready for data
lsu_araddr_i  input  ADDR_WIDTH  LSU read address
lsu_arvalid_i  input  1  LSU address valid
lsu_arready_o  output  1  LSU address accepted
lsu_rdata_o  output  DATA_WIDTH  LSU read data
lsu_rvalid_o  output  1  LSU read data valid
lsu_rready_i  input  1  LSU ready for data
araddr_o  output  ADDR_WIDTH  slave read address
arvalid_o  output  1  slave address valid
arready_i  input  1  slave address ready
rdata_i  input  DATA_WIDTH  slave read data
rvalid_i  input  1  slave data valid
rready_o  output  1  slave data ready
busy_o  output  1  transaction in progress (state != IDLE)

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE; grant = IFU; last_grant = IFU.
  - All valid/ready outputs = 0; araddr_o = 0; busy_o = 0.
- State IDLE:
  - arvalid_o = 0, rready_o = 0, both m_arready = 0.
  - If either arvalid_i is high, register grant and go to ADDR. Stay in IDLE otherwise.
- Grant selection (sampled in IDLE):
  - Single requester: that master wins.
  - Both requesting with FIXED_PRIO=1: LSU wins.
  - Both requesting with FIXED_PRIO=0: the master != last_grant wins.
- State ADDR:
  - araddr_o and arvalid_o mux from the granted master.
  - Granted m_arready = arready_i; the other master's arready = 0.
  - On arvalid_o & arready_i: go to DATA.
  - If the granted master drops arvalid before the handshake (e.g. flush): abandon, go to IDLE, last_grant unchanged.
- State DATA:
  - rready_o = granted rready_i. Granted m_rvalid = rvalid_i; the other master's rvalid = 0.
  - On rvalid_i & rready_o: last_grant <= grant, go to IDLE.
  - rvalid is held indefinitely while the master's rready is low. There is no timeout.
- rdata to masters:
  - ifu_rdata_o and lsu_rdata_o both carry rdata_i unconditionally.
  - Only the granted master's rvalid qualifies the data.
- Combinational paths:
  - No comb path from any m_arvalid to arvalid_o in IDLE. This gives 1 cycle of arbitration latency.
  - Comb paths arready_i→m_arready and rvalid_i→m_rvalid exist in ADDR/DATA only.
- Throughput: a zero-wait slave completes one read per 3 cycles (IDLE, ADDR, DATA).
- Request arriving during a transaction: the non-granted master's arvalid stays pending (arready=0) until the next IDLE.
- Reset mid-transaction: returns immediately to IDLE with outputs at reset values. The slave is reset on the same rst_i.

Test Plan:
- IFU alone, araddr=0x8000_0000, slave ready immediately, rdata=0x0000_0013_0000_0297 → arvalid_o at cycle 1, ifu_arready_o pulse at cycle 1, ifu_rvalid_o at cycle 2 with that data, lsu_rvalid_o = 0 throughout.
- Both request in the same cycle after reset, FIXED_PRIO=0 → LSU (0x8000_1000) granted first. IFU (0x8000_0004) is served next. A third simultaneous pair is granted to LSU again.
- FIXED_PRIO=1, both masters request continuously for 4 transactions → all 4 grants go to LSU. IFU arready stays 0.
- Slave arready held low for 5 cycles, then LSU rready held low for 3 cycles after rvalid_i → arvalid_o/araddr_o are stable, no state advance, data is delivered on the rready cycle, busy_o stays 1 throughout.
- IFU granted, then drops arvalid in ADDR before arready_i → returns to IDLE, no slave handshake, a pending LSU request is granted next.
- rst_i asserted asynchronously while in DATA → busy_o, arvalid_o, rready_o and both rvalid outputs go to 0 without a clock edge. After release, the first tie goes to LSU.
